// File: rtl/led7seg_scan_ctrl.sv
// led7seg_scan_ctrl: N-digit multiplexed 7-segment driver for common-anode boards.
// Hex decode, time-division digit scan, per-digit decimal point, and a double-buffered
// display value that only changes at a frame boundary.
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero blanking.
module led7seg_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] disp_reg;
  logic [4*N_DIGITS-1:0] pend_reg;
  logic [N_DIGITS-1:0]   disp_dp;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_next;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [6:0]            seg_dec;
`ifdef SEG7_LZ_BLANK_EN
  logic                  zero_run;
`endif

  // Prescaler terminal count and frame wrap (last digit finishing its slot)
  always_comb begin
    tick = en && (div_cnt == CNT_LAST);
    wrap = tick && (idx == IDX_LAST);
  end

  // Leading-zero mask: digit k>0 is blank when nibbles k..N_DIGITS-1 are all zero
  always_comb begin
    lz_blank = '0;
`ifdef SEG7_LZ_BLANK_EN
    zero_run = 1'b1;
    for (int unsigned k = N_DIGITS; k > 0; k--) begin
      zero_run = zero_run && (disp_reg[4*(k-1) +: 4] == 4'h0);
      if (k > 1) lz_blank[k-1] = zero_run;
    end
`endif
  end

  // Select the nibble, dp bit and blank flag of the digit being scanned; one-hot-low anode
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib    = disp_reg[4*k +: 4];
        cur_dp     = disp_dp[k];
        cur_blank  = lz_blank[k];
        an_next[k] = 1'b0;
      end
    end
  end

  // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    case (cur_nib)
      4'h0:    seg_dec = 7'b1000000;
      4'h1:    seg_dec = 7'b1111001;
      4'h2:    seg_dec = 7'b0100100;
      4'h3:    seg_dec = 7'b0110000;
      4'h4:    seg_dec = 7'b0011001;
      4'h5:    seg_dec = 7'b0010010;
      4'h6:    seg_dec = 7'b0000010;
      4'h7:    seg_dec = 7'b1111000;
      4'h8:    seg_dec = 7'b0000000;
      4'h9:    seg_dec = 7'b0010000;
      4'hA:    seg_dec = 7'b0001000;
      4'hB:    seg_dec = 7'b0000011;
      4'hC:    seg_dec = 7'b1000110;
      4'hD:    seg_dec = 7'b0100001;
      4'hE:    seg_dec = 7'b0000110;
      default: seg_dec = 7'b0001110;
    endcase
  end

  // Prescaler and digit index; both freeze while scanning is disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (en) begin
      if (tick) begin
        div_cnt <= '0;
        idx     <= wrap ? '0 : idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  // Double buffer: loads land in pend_*, and move to disp_* only on a frame wrap.
  // A load on the wrap edge commits the old pend_* and keeps pending set for the new one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_reg   <= '0;
      disp_dp    <= '0;
      pend_reg   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (wrap && pending) begin
        disp_reg <= pend_reg;
        disp_dp  <= pend_dp;
      end
      if (load) begin
        pend_reg <= data_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end else if (wrap) begin
        pending  <= 1'b0;
      end
    end
  end

  // Registered pin drive from the current idx; dark while in reset or disabled
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= cur_blank ? 7'h7F : seg_dec;
      dp  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Testbench for led7seg_scan_ctrl (N_DIGITS=4, REFRESH_DIV=4).
// A cycle model pushes expected pin values into a scoreboard queue on every edge;
// each scenario task pops and compares, and also checks fixed expectations.
module tb_led7seg_scan_ctrl;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam logic [13:0] RST_OUT = {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  data_in = '0;
  logic [3:0]   dp_in = '0;
  logic         pending;
  logic         frame_tick;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp;
  logic [13:0]  obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] sb[$];

  led7seg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in), .dp_in(dp_in),
    .pending(pending), .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;
  assign obs = {pending, frame_tick, an, seg, dp};

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    for (int k = 0; k < N; k++) if (a === ~(4'b0001 << k)) return k;
    return -1;
  endfunction

  // Reference model state
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_ddp = '0, m_pdp = '0;
  logic        m_pending = 1'b0;
  logic        m_tk, m_wr, m_pn, m_blank, m_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  // Model: combinational view of the next edge
  always_comb begin
    m_tk    = en && (m_cnt == DIV - 1);
    m_wr    = m_tk && (m_idx == N - 1);
    m_pn    = load ? 1'b1 : (m_wr ? 1'b0 : m_pending);
    m_blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    m_blank = (m_idx > 0) && ((m_disp >> (4 * m_idx)) == 16'h0);
`endif
    if (en) begin
      m_an  = ~(4'b0001 << m_idx);
      m_seg = m_blank ? 7'h7F : ref_seg(m_disp[4*m_idx +: 4]);
      m_dp  = ~m_ddp[m_idx];
    end else begin
      m_an  = 4'hF;
      m_seg = 7'h7F;
      m_dp  = 1'b1;
    end
  end

  // Model: state update and scoreboard push
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= 0; m_idx <= 0; m_disp <= '0; m_pend <= '0;
      m_ddp <= '0; m_pdp <= '0; m_pending <= 1'b0;
      sb.push_back(RST_OUT);
    end else begin
      if (m_wr && m_pending) begin m_disp <= m_pend; m_ddp <= m_pdp; end
      if (load) begin m_pend <= data_in; m_pdp <= dp_in; end
      m_pending <= m_pn;
      if (en) m_cnt <= m_tk ? 0 : m_cnt + 1;
      if (m_tk) m_idx <= m_wr ? 0 : m_idx + 1;
      sb.push_back({m_pn, m_wr, m_an, m_seg, m_dp});
    end
  end

  task automatic cyc(output logic [13:0] e);
    @(posedge clk);
    #1;
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst_n = 1'b0; en = 1'b1; load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF;
    for (int i = 0; i < 2; i++) begin
      cyc(e);
      n_tests++; if (obs !== RST_OUT) begin n_fail++; $display("FAIL reset_out: got %h expected %h", obs, RST_OUT); end
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL reset_model: got %h expected %h", obs, e); end
    end
    rst_n = 1'b1; en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    cyc(e);
    n_tests++; if (obs !== RST_OUT) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, RST_OUT); end
  endtask

  task automatic test_scan();
    logic [13:0] e;
    en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL scan_model j=%0d: got %h expected %h", j, obs, e); end
      n_tests++;
      if (an !== ~(4'b0001 << ((j / 4) % 4)) || seg !== 7'b1000000 || dp !== 1'b1) begin
        n_fail++; $display("FAIL scan_digit j=%0d: got an=%b seg=%b dp=%b", j, an, seg, dp);
      end
      n_tests++;
      if (frame_tick !== ((j % 16) == 15)) begin
        n_fail++; $display("FAIL scan_frame_tick j=%0d: got %b expected %b", j, frame_tick, (j % 16) == 15);
      end
    end
  endtask

  task automatic test_load();
    logic [13:0] e;
    logic [6:0]  xs [4];
    logic [3:0]  xdp;
    bit          seen;
    int          d;
    xs  = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    xdp = 4'b1011;
    data_in = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    cyc(e);
    n_tests++; if (pending !== 1'b1 || obs !== e) begin n_fail++; $display("FAIL load_capture: got %h expected %h", obs, e); end
    load = 1'b0; data_in = '0; dp_in = '0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL load_model: got %h expected %h", obs, e); end
      if (frame_tick === 1'b1) begin
        seen = 1;
        n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL load_commit_clear: got %b expected 0", pending); end
      end else begin
        n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending_hold: got %b expected 1", pending); end
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL load_wait_frame: got no frame_tick expected one within 40 cycles"); end
    for (int i = 0; i < 16; i++) begin
      cyc(e);
      d = digit_of(an);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL load_frame_model: got %h expected %h", obs, e); end
      n_tests++;
      if (d < 0 || seg !== xs[d] || dp !== xdp[d]) begin
        n_fail++; $display("FAIL load_display: got an=%b seg=%b dp=%b", an, seg, dp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    bit          seen;
    data_in = 16'h1111; load = 1'b1;
    cyc(e);
    data_in = 16'h2222;
    cyc(e);
    load = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL b2b_model: got %h expected %h", obs, e); end
      if (frame_tick === 1'b1) seen = 1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_wait_frame: got no frame_tick expected one within 40 cycles"); end
    for (int i = 0; i < 16; i++) begin
      cyc(e);
      n_tests++; if (obs !== e || seg !== 7'b0100100) begin n_fail++; $display("FAIL b2b_last_wins: got seg=%b expected 0100100", seg); end
    end
    // Scan is now at the start of a frame: load early, then load again on the wrap edge
    data_in = 16'h4444; load = 1'b1;
    cyc(e);
    load = 1'b0;
    for (int i = 0; i < 14; i++) cyc(e);
    data_in = 16'h3333; load = 1'b1;
    cyc(e);
    load = 1'b0;
    n_tests++;
    if (frame_tick !== 1'b1 || pending !== 1'b1) begin
      n_fail++; $display("FAIL wrap_load_edge: got frame_tick=%b pending=%b expected 1 1", frame_tick, pending);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(e);
      n_tests++; if (obs !== e || seg !== 7'b0011001) begin n_fail++; $display("FAIL wrap_load_old: got seg=%b expected 0011001", seg); end
      if (i == 15) begin
        n_tests++; if (frame_tick !== 1'b1 || pending !== 1'b0) begin n_fail++; $display("FAIL wrap_load_second: got ft=%b pend=%b expected 1 0", frame_tick, pending); end
      end else begin
        n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL wrap_load_pend: got %b expected 1", pending); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(e);
      n_tests++; if (obs !== e || seg !== 7'b0110000) begin n_fail++; $display("FAIL wrap_load_new: got seg=%b expected 0110000", seg); end
    end
  endtask

  task automatic test_enable();
    logic [13:0] e;
    for (int i = 0; i < 5; i++) begin
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL en_pre_model: got %h expected %h", obs, e); end
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load = (i == 3); data_in = 16'h8888;
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL en_off_model: got %h expected %h", obs, e); end
      n_tests++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
        n_fail++; $display("FAIL en_off_dark: got an=%b seg=%b dp=%b ft=%b", an, seg, dp, frame_tick);
      end
    end
    load = 1'b0;
    n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL en_off_load: got pending=%b expected 1", pending); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL en_resume_model: got %h expected %h", obs, e); end
      n_tests++;
      if (an !== ((i < 3) ? 4'b1101 : 4'b1011)) begin
        n_fail++; $display("FAIL en_resume_digit i=%0d: got an=%b expected %b", i, an, (i < 3) ? 4'b1101 : 4'b1011);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    n_tests++; if (pending !== 1'b1 || an !== 4'b1011) begin n_fail++; $display("FAIL rst_mid_setup: got pend=%b an=%b expected 1 1011", pending, an); end
    rst_n = 1'b0;
    cyc(e);
    n_tests++; if (obs !== RST_OUT || obs !== e) begin n_fail++; $display("FAIL rst_mid_out: got %h expected %h", obs, RST_OUT); end
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      cyc(e);
      n_tests++; if (obs !== e) begin n_fail++; $display("FAIL rst_mid_model: got %h expected %h", obs, e); end
      n_tests++;
      if (an !== ~(4'b0001 << ((j / 4) % 4)) || seg !== 7'b1000000 || pending !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_restart j=%0d: got an=%b seg=%b pend=%b", j, an, seg, pending);
      end
    end
  endtask

  task automatic test_lz();
    logic [13:0] e;
    logic [6:0]  xs [4];
    logic [15:0] vals [2];
    bit          seen;
    int          d;
    vals = '{16'h0050, 16'h0000};
    for (int v = 0; v < 2; v++) begin
`ifdef SEG7_LZ_BLANK_EN
      xs = '{7'b1000000, (v == 0) ? 7'b0010010 : 7'h7F, 7'h7F, 7'h7F};
`else
      xs = '{7'b1000000, (v == 0) ? 7'b0010010 : 7'b1000000, 7'b1000000, 7'b1000000};
`endif
      data_in = vals[v]; dp_in = '0; load = 1'b1;
      cyc(e);
      load = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        cyc(e);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL lz_model: got %h expected %h", obs, e); end
        if (frame_tick === 1'b1) seen = 1;
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL lz_wait_frame: got no frame_tick expected one within 40 cycles"); end
      for (int i = 0; i < 16; i++) begin
        cyc(e);
        d = digit_of(an);
        n_tests++; if (obs !== e) begin n_fail++; $display("FAIL lz_frame_model: got %h expected %h", obs, e); end
        n_tests++;
        if (d < 0 || seg !== xs[d] || dp !== 1'b1) begin
          n_fail++; $display("FAIL lz_display val=%h: got an=%b seg=%b dp=%b", vals[v], an, seg, dp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_lz();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
